// File: rtl/atm_cell_pkg.sv
// Shared constants, receive-state encoding and CRC helper for the ATM cell receiver.
package atm_cell_pkg;

  localparam int unsigned CELL_BYTES = 53;
  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned HEC_IDX    = 4;
  localparam logic [7:0]  HEC_COSET  = 8'h55;
  localparam logic [7:0]  CRC8_POLY  = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } rx_state_e;

  // MSB-first CRC-8 update of one byte.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/atm_cell_rx_hec.sv
// Header error check: running CRC over header bytes 0-3, compared against byte 4.
module atm_hec_check
  import atm_cell_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_vld,
  input  logic [5:0] byte_idx,
  input  logic [7:0] data,
  output logic       hec_bad
);

  logic [7:0] crc_q, crc_d;
  logic       bad_q, bad_d;

  always_comb begin
    crc_d = crc_q;
    bad_d = bad_q;
    if (byte_vld) begin
      if (byte_idx == 6'd0) begin
        crc_d = crc8_byte('0, data);
        bad_d = 1'b0;
      end else if (32'(byte_idx) < HDR_BYTES) begin
        crc_d = crc8_byte(crc_q, data);
      end else if (32'(byte_idx) == HEC_IDX) begin
        bad_d = (data != (crc_q ^ HEC_COSET));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
      bad_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      bad_q <= bad_d;
    end
  end

  assign hec_bad = bad_q;

endmodule

// File: rtl/atm_cell_rx.sv
// UTOPIA-style 8-bit cell receiver: assembles 53-byte cells, checks HEC,
// buffers NUM_CELLS cells and streams them out on a valid/ready interface.
module atm_cell_rx
  import atm_cell_pkg::*;
#(
  parameter int unsigned NUM_CELLS    = 2,
  parameter bit          DROP_BAD_HEC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        soc,
  input  logic        en,
  output logic        clav,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_hec_err,
  output logic [15:0] hec_err_cnt,
  output logic [15:0] runt_cnt,
  output logic [15:0] ovf_cnt
);

  localparam int unsigned SW = $clog2(NUM_CELLS);
  localparam int unsigned CW = $clog2(NUM_CELLS + 1);
  localparam int unsigned AW = $clog2(NUM_CELLS * CELL_BYTES);
  localparam logic [5:0]  LAST_IDX = 6'(CELL_BYTES - 1);

  rx_state_e     st_q, st_d;
  logic [5:0]    idx_q, idx_d;
  logic [SW-1:0] wr_slot_q, wr_slot_d;
  logic [SW-1:0] rd_slot_q, rd_slot_d;
  logic [5:0]    rd_idx_q, rd_idx_d;
  logic [CW-1:0] cells_q, cells_d;
  logic          clav_q, clav_d;
  logic [15:0]   hec_cnt_q, hec_cnt_d;
  logic [15:0]   runt_cnt_q, runt_cnt_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  logic [7:0]    mem_q [NUM_CELLS*CELL_BYTES];
  logic          hec_flag_q [NUM_CELLS];

  logic          take;
  logic [5:0]    take_idx;
  logic          commit;
  logic          rel;
  logic          hec_bad;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  atm_hec_check u_hec (
    .clk      (clk),
    .rst      (rst),
    .byte_vld (take),
    .byte_idx (take_idx),
    .data     (data),
    .hec_bad  (hec_bad)
  );

  assign out_valid = (cells_q != '0);

  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    rd_idx_d   = rd_idx_q;
    hec_cnt_d  = hec_cnt_q;
    runt_cnt_d = runt_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    take       = 1'b0;
    take_idx   = '0;
    commit     = 1'b0;
    rel        = 1'b0;

    if (!en) begin
      if (soc) begin
        // An early soc reuses the reserved slot: rewinding is just restarting the byte index.
        if (st_q != IDLE) begin
          runt_cnt_d = sat_inc16(runt_cnt_q);
          take       = 1'b1;
          st_d       = HDR;
          idx_d      = 6'd1;
        end else if (clav_q) begin
          take  = 1'b1;
          st_d  = HDR;
          idx_d = 6'd1;
        end else begin
          ovf_cnt_d = sat_inc16(ovf_cnt_q);
        end
      end else if (st_q != IDLE) begin
        take     = 1'b1;
        take_idx = idx_q;
        idx_d    = idx_q + 6'd1;
        if (idx_q == 6'(HEC_IDX)) st_d = PAYLOAD;
        if (idx_q == LAST_IDX) begin
          st_d  = IDLE;
          idx_d = '0;
          if (hec_bad) hec_cnt_d = sat_inc16(hec_cnt_q);
          commit = !(hec_bad && DROP_BAD_HEC);
          if (commit) wr_slot_d = wr_slot_q + 1'b1;
        end
      end
    end

    if (out_valid && out_ready) begin
      if (rd_idx_q == LAST_IDX) begin
        rel       = 1'b1;
        rd_idx_d  = '0;
        rd_slot_d = rd_slot_q + 1'b1;
      end else begin
        rd_idx_d = rd_idx_q + 6'd1;
      end
    end

    cells_d = cells_q + CW'(commit) - CW'(rel);
    clav_d  = ({1'b0, cells_d} + (CW+1)'(st_d != IDLE)) < (CW+1)'(NUM_CELLS);
  end

  assign wr_addr = AW'(wr_slot_q) * AW'(CELL_BYTES) + AW'(take_idx);
  assign rd_addr = AW'(rd_slot_q) * AW'(CELL_BYTES) + AW'(rd_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      idx_q      <= '0;
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      rd_idx_q   <= '0;
      cells_q    <= '0;
      clav_q     <= 1'b0;
      hec_cnt_q  <= '0;
      runt_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      st_q       <= st_d;
      idx_q      <= idx_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      rd_idx_q   <= rd_idx_d;
      cells_q    <= cells_d;
      clav_q     <= clav_d;
      hec_cnt_q  <= hec_cnt_d;
      runt_cnt_q <= runt_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take) mem_q[wr_addr] <= data;
    if (commit) hec_flag_q[wr_slot_q] <= hec_bad;
  end

  assign clav        = clav_q;
  assign out_data    = mem_q[rd_addr];
  assign out_sop     = out_valid && (rd_idx_q == '0);
  assign out_eop     = out_valid && (rd_idx_q == LAST_IDX);
  assign out_hec_err = out_valid && hec_flag_q[rd_slot_q];
  assign hec_err_cnt = hec_cnt_q;
  assign runt_cnt    = runt_cnt_q;
  assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_atm_cell_rx.sv
// Scoreboard bench for atm_cell_rx: one instance drops bad-HEC cells, one keeps and flags them.
module tb_atm_cell_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, soc, out_ready;
  logic [7:0] data;

  logic        d_clav, d_valid, d_sop, d_eop, d_hec;
  logic [7:0]  d_data;
  logic [15:0] d_hcnt, d_rcnt, d_ocnt;
  logic        k_clav, k_valid, k_sop, k_eop, k_hec;
  logic [7:0]  k_data;
  logic [15:0] k_hcnt, k_rcnt, k_ocnt;

  atm_cell_rx #(.NUM_CELLS(2), .DROP_BAD_HEC(1'b1)) u_drop (
    .clk(clk), .rst(rst), .data(data), .soc(soc), .en(en), .clav(d_clav),
    .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready), .out_sop(d_sop),
    .out_eop(d_eop), .out_hec_err(d_hec), .hec_err_cnt(d_hcnt), .runt_cnt(d_rcnt),
    .ovf_cnt(d_ocnt)
  );

  atm_cell_rx #(.NUM_CELLS(2), .DROP_BAD_HEC(1'b0)) u_keep (
    .clk(clk), .rst(rst), .data(data), .soc(soc), .en(en), .clav(k_clav),
    .out_data(k_data), .out_valid(k_valid), .out_ready(out_ready), .out_sop(k_sop),
    .out_eop(k_eop), .out_hec_err(k_hec), .hec_err_cnt(k_hcnt), .runt_cnt(k_rcnt),
    .ovf_cnt(k_ocnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_hec = 0, exp_runt = 0, exp_ovf = 0;
  logic [10:0] q_d[$];
  logic [10:0] q_k[$];
  logic [7:0]  cur [53];
  logic        rnd_rdy = 1'b0;
  logic        rdy_force = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? ($urandom_range(3) != 0) : rdy_force;
  end

  // HEC as the remainder of header*x^8 divided by x^8+x^2+x+1, then the coset.
  function automatic logic [7:0] ref_hec(input logic [31:0] h);
    logic [39:0] r;
    r = {h, 8'h00};
    for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0] ^ 8'h55;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mon(input bit keep, input logic v, input logic r, input logic [10:0] got);
    logic [10:0] exp;
    if (!v) return;
    checks++;
    if ((keep ? q_k.size() : q_d.size()) == 0) begin
      errors++;
      $display("FAIL %s: got %03h expected no output", keep ? "out_keep" : "out_drop", got);
      return;
    end
    exp = keep ? q_k[0] : q_d[0];
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", keep ? "out_keep" : "out_drop", got, exp);
    end
    if (r) begin
      if (keep) void'(q_k.pop_front());
      else void'(q_d.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(1'b0, d_valid, out_ready, {d_hec, d_sop, d_eop, d_data});
      mon(1'b1, k_valid, out_ready, {k_hec, k_sop, k_eop, k_data});
    end
  end

  task automatic put(input logic e, input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    en = e; soc = s; data = d;
  endtask

  task automatic idle_cyc();
    put(1'b1, 1'($urandom_range(1)), 8'($urandom));
  endtask

  task automatic make_cell(input logic [31:0] hdr, input bit good);
    logic [7:0] hv;
    hv = ref_hec(hdr);
    for (int i = 0; i < 4; i++) cur[i] = hdr[31-8*i -: 8];
    cur[4] = good ? hv : (hv ^ (8'd1 << $urandom_range(7)));
    for (int i = 5; i < 53; i++) cur[i] = 8'($urandom);
  endtask

  task automatic expect_cell();
    bit good;
    good = (cur[4] == ref_hec({cur[0], cur[1], cur[2], cur[3]}));
    if (!good) exp_hec++;
    for (int i = 0; i < 53; i++) begin
      if (good) q_d.push_back({1'b0, i == 0, i == 52, cur[i]});
      q_k.push_back({!good, i == 0, i == 52, cur[i]});
    end
  endtask

  task automatic wait_clav();
    int n;
    n = 0;
    while (!(d_clav && k_clav)) begin
      if (++n > 3000) begin
        chk("clav_wait_timeout", 0, 1);
        return;
      end
      idle_cyc();
    end
  endtask

  // n_bytes < 53 leaves a truncated cell with no trailing idle, so a following cell aborts it.
  task automatic send_cell(input int n_bytes, input bit wait_c, input int pause_pct,
                           input int pause_at, input int clav_after);
    if (wait_c) wait_clav();
    for (int i = 0; i < n_bytes; i++) begin
      if (i != 0) while (int'($urandom_range(99)) < pause_pct) idle_cyc();
      if (i == pause_at) repeat (3) idle_cyc();
      put(1'b0, i == 0, cur[i]);
      if (i == 1 && clav_after >= 0) begin
        chk("clav_after_soc_drop", int'(d_clav), clav_after);
        chk("clav_after_soc_keep", int'(k_clav), clav_after);
      end
    end
    if (n_bytes == 53) put(1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_cnts();
    chk("hec_cnt_drop", int'(d_hcnt), exp_hec);
    chk("hec_cnt_keep", int'(k_hcnt), exp_hec);
    chk("runt_cnt_drop", int'(d_rcnt), exp_runt);
    chk("runt_cnt_keep", int'(k_rcnt), exp_runt);
    chk("ovf_cnt_drop", int'(d_ocnt), exp_ovf);
    chk("ovf_cnt_keep", int'(k_ocnt), exp_ovf);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_rdy = 1'b0;
    rdy_force = 1'b1;
    while (q_d.size() != 0 || q_k.size() != 0) begin
      @(posedge clk);
      if (++n > 3000) begin
        chk("drain_timeout", q_d.size() + q_k.size(), 0);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drained_valid_drop", int'(d_valid), 0);
    chk("drained_valid_keep", int'(k_valid), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; soc = 1'b0; data = 8'h00;

    repeat (3) begin
      @(negedge clk);
      chk("rst_clav_drop", int'(d_clav), 0);
      chk("rst_clav_keep", int'(k_clav), 0);
      chk("rst_valid_drop", int'(d_valid), 0);
      chk("rst_valid_keep", int'(k_valid), 0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("clav_after_rst_drop", int'(d_clav), 1);
    chk("clav_after_rst_keep", int'(k_clav), 1);
    check_cnts();

    // Good cell with the all-zero header and a counting payload.
    rdy_force = 1'b1;
    for (int i = 0; i < 4; i++) cur[i] = 8'h00;
    cur[4] = 8'h55;
    for (int i = 5; i < 53; i++) cur[i] = 8'(i - 5);
    expect_cell();
    send_cell(53, 1'b1, 0, -1, -1);
    drain();
    check_cnts();

    // Same cell with a corrupted HEC, then an idle cell.
    cur[4] = 8'h54;
    expect_cell();
    send_cell(53, 1'b1, 0, -1, -1);
    make_cell(32'h0000_0001, 1'b1);
    chk("idle_cell_hec_model", int'(cur[4]), 'h52);
    expect_cell();
    send_cell(53, 1'b1, 0, -1, -1);
    drain();
    check_cnts();

    // Back-pressure fills both slots; a third soc overflows.
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    make_cell($urandom, 1'b1); expect_cell(); send_cell(53, 1'b1, 0, -1, -1);
    make_cell($urandom, 1'b1); expect_cell(); send_cell(53, 1'b1, 0, -1, 0);
    make_cell($urandom, 1'b1); exp_ovf++; send_cell(53, 1'b0, 0, -1, -1);
    check_cnts();
    rdy_force = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d_valid && d_eop) && n < 300);
    chk("first_eop_seen", int'(d_valid && d_eop), 1);
    chk("clav_at_eop_drop", int'(d_clav), 0);
    chk("clav_at_eop_keep", int'(k_clav), 0);
    @(negedge clk);
    chk("clav_after_eop_drop", int'(d_clav), 1);
    chk("clav_after_eop_keep", int'(k_clav), 1);
    drain();

    // Runt aborted at byte 20, then a cell with a 3-cycle pause mid-payload.
    make_cell($urandom, 1'b1);
    send_cell(20, 1'b1, 0, -1, -1);
    exp_runt++;
    make_cell($urandom, 1'b1); expect_cell();
    send_cell(53, 1'b0, 0, 30, -1);
    drain();
    check_cnts();

    // Random cells, random pauses, random HEC faults, random runts, random out_ready.
    rnd_rdy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if ($urandom_range(5) == 0) begin
        make_cell($urandom, 1'b1);
        send_cell(int'($urandom_range(5, 50)), 1'b1, 10, -1, -1);
        exp_runt++;
        make_cell($urandom, $urandom_range(3) != 0); expect_cell();
        send_cell(53, 1'b0, 10, -1, -1);
      end else begin
        make_cell($urandom, $urandom_range(3) != 0); expect_cell();
        send_cell(53, 1'b1, 10, -1, -1);
      end
    end
    drain();
    check_cnts();

    // Reset at byte 30 with one committed cell held by back-pressure.
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    make_cell($urandom, 1'b1); expect_cell(); send_cell(53, 1'b1, 0, -1, -1);
    make_cell($urandom, 1'b1); send_cell(30, 1'b1, 0, -1, -1);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; soc = 1'b0;
    @(posedge clk); #1;
    q_d.delete(); q_k.delete();
    exp_hec = 0; exp_runt = 0; exp_ovf = 0;
    chk("midrst_valid_drop", int'(d_valid), 0);
    chk("midrst_valid_keep", int'(k_valid), 0);
    chk("midrst_clav_drop", int'(d_clav), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("post_midrst_clav_drop", int'(d_clav), 1);
    chk("post_midrst_clav_keep", int'(k_clav), 1);
    chk("post_midrst_valid_keep", int'(k_valid), 0);
    check_cnts();
    rdy_force = 1'b1;
    make_cell($urandom, 1'b1); expect_cell(); send_cell(53, 1'b1, 0, -1, -1);
    drain();
    check_cnts();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
